matrix_stream_loader: RTL and testbench

Parametrised loader that fills the shared `matrix` element-write port from a valid/ready data stream, replacing the hand-driven `ini_*` initialisation path in front of the LDL decomposer. It walks row-major addresses itself and supports a symmetric mode: only the upper triangle is streamed, and each off-diagonal element is mirrored to its transposed location. `owns_port` drives the matrix port mux select.

---
 rtl/matrix_stream_loader.sv | 151 +++++++++++++++
 tb/tb_matrix_stream_loader.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/matrix_stream_loader.sv
// matrix_stream_loader
//   Fills the shared matrix element-write port from a valid/ready stream,
//   walking row-major addresses internally. In symmetric mode only the upper
//   triangle is streamed and every off-diagonal element is written a second
//   time at its transposed location.
//
// Ports
//   clk, rst          : rising-edge clock, synchronous active-high reset
//   start, symmetric  : begin a load (IDLE only); mode captured with start
//   abort             : drop the load in progress, no finished pulse
//   in_data, in_valid : stream element and its valid
//   in_ready          : loader accepts a beat this cycle (state only)
//   write_row_addr,
//   write_col_addr,
//   write_data        : registered matrix write; hold value when idle
//   write_ready       : one-cycle write strobe
//   busy, owns_port   : load in progress / matrix port mux select
//   finished          : one-cycle pulse one cycle after the final strobe
//
// Handshake: a beat transfers on a rising edge where in_valid && in_ready;
// in_ready never depends on in_valid, and an abort in the same cycle wins
// over the transfer (the beat is dropped).
module matrix_stream_loader #(
    parameter int NUM_ROWS    = 169,
    parameter int NUM_COLS    = 169,
    parameter int SCALAR_BITS = 32,
    localparam int ROW_ADDR_WIDTH = $clog2(NUM_ROWS),
    localparam int COL_ADDR_WIDTH = $clog2(NUM_COLS)
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      start,
    input  logic                      symmetric,
    input  logic                      abort,
    input  logic [SCALAR_BITS-1:0]    in_data,
    input  logic                      in_valid,
    output logic                      in_ready,
    output logic [ROW_ADDR_WIDTH-1:0] write_row_addr,
    output logic [COL_ADDR_WIDTH-1:0] write_col_addr,
    output logic [SCALAR_BITS-1:0]    write_data,
    output logic                      write_ready,
    output logic                      busy,
    output logic                      owns_port,
    output logic                      finished
);

    typedef enum logic [1:0] {IDLE, STREAM, MIRROR, FLUSH} state_t;

    localparam logic [ROW_ADDR_WIDTH-1:0] ROW_LAST = ROW_ADDR_WIDTH'(NUM_ROWS - 1);
    localparam logic [COL_ADDR_WIDTH-1:0] COL_LAST = COL_ADDR_WIDTH'(NUM_COLS - 1);

    state_t                    state, state_next;
    logic [ROW_ADDR_WIDTH-1:0] r;
    logic [COL_ADDR_WIDTH-1:0] c;
    logic                      sym;
    logic                      last_q;     // the beat behind a pending mirror was the last one
    logic                      accept;
    logic                      mirror_wr;
    logic                      done;
    logic                      at_last;
    logic                      off_diag;

    assign at_last   = (r == ROW_LAST) && (c == COL_LAST);
    assign off_diag  = sym && (int'(r) != int'(c));
    assign in_ready  = (state == STREAM);
    assign busy      = (state != IDLE);
    assign owns_port = busy;

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    always_comb begin
        state_next = state;
        accept     = 1'b0;
        mirror_wr  = 1'b0;
        done       = 1'b0;
        case (state)
            IDLE: begin
                if (start) state_next = STREAM;
            end
            STREAM: begin
                if (in_valid) begin
                    accept = 1'b1;
                    if (off_diag)     state_next = MIRROR;
                    else if (at_last) state_next = FLUSH;
                end
            end
            MIRROR: begin
                mirror_wr  = 1'b1;
                state_next = last_q ? FLUSH : STREAM;
            end
            FLUSH: begin
                done       = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
        // Abort suppresses any write or completion decided this cycle.
        if (abort && state != IDLE) begin
            state_next = IDLE;
            accept     = 1'b0;
            mirror_wr  = 1'b0;
            done       = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r              <= '0;
            c              <= '0;
            sym            <= 1'b0;
            last_q         <= 1'b0;
            write_row_addr <= '0;
            write_col_addr <= '0;
            write_data     <= '0;
            write_ready    <= 1'b0;
            finished       <= 1'b0;
        end else begin
            write_ready <= 1'b0;
            finished    <= done;
            if (state == IDLE && start) begin
                r   <= '0;
                c   <= '0;
                sym <= symmetric;
            end
            if (accept) begin
                write_row_addr <= r;
                write_col_addr <= c;
                write_data     <= in_data;
                write_ready    <= 1'b1;
                last_q         <= at_last;
                if (c == COL_LAST) begin
                    r <= r + ROW_ADDR_WIDTH'(1);
                    // Symmetric mode restarts each row on the next diagonal.
                    c <= sym ? (COL_ADDR_WIDTH'(r) + COL_ADDR_WIDTH'(1)) : '0;
                end else begin
                    c <= c + COL_ADDR_WIDTH'(1);
                end
            end
            // The outputs still hold the primary write, so the mirror is a swap.
            if (mirror_wr) begin
                write_row_addr <= ROW_ADDR_WIDTH'(write_col_addr);
                write_col_addr <= COL_ADDR_WIDTH'(write_row_addr);
                write_ready    <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_matrix_stream_loader.sv
module tb_matrix_stream_loader;

    localparam int N  = 3;
    localparam int SB = 32;
    localparam int AW = 2;
    localparam int W  = 2 * AW + SB;

    logic          clk;
    logic          rst;
    logic          start;
    logic          symmetric;
    logic          abort;
    logic [SB-1:0] in_data;
    logic          in_valid;
    logic          in_ready;
    logic [AW-1:0] write_row_addr;
    logic [AW-1:0] write_col_addr;
    logic [SB-1:0] write_data;
    logic          write_ready;
    logic          busy;
    logic          owns_port;
    logic          finished;

    matrix_stream_loader #(.NUM_ROWS(N), .NUM_COLS(N), .SCALAR_BITS(SB)) dut (
        .clk(clk), .rst(rst), .start(start), .symmetric(symmetric), .abort(abort),
        .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .write_row_addr(write_row_addr), .write_col_addr(write_col_addr),
        .write_data(write_data), .write_ready(write_ready), .busy(busy),
        .owns_port(owns_port), .finished(finished)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- scoreboard state ----------------
    int            errors = 0;
    int            checks = 0;
    int            cyc = 0;
    int            last_strobe_cyc = 0;
    int            fin_cnt = 0;
    bit            fin_expected = 0;
    logic [W-1:0]  exp_q[$];
    int            strobe_cycles[$];
    logic [SB-1:0] beat_data[$];
    logic [W-1:0]  exp_e;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp_v);
        checks++;
        if (act !== exp_v) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp_v);
        end
    endtask

    always @(negedge clk) begin
        cyc++;
        if (write_ready === 1'b1) begin
            strobe_cycles.push_back(cyc);
            last_strobe_cyc = cyc;
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_strobe: got (%0d,%0d)=%0h expected no strobe",
                         write_row_addr, write_col_addr, write_data);
            end else begin
                exp_e = exp_q.pop_front();
                check("strobe", 64'({write_row_addr, write_col_addr, write_data}), 64'(exp_e));
            end
        end
        if (finished === 1'b1) begin
            fin_cnt++;
            check("finish_expected", 64'(fin_expected), 64'(1));
            check("finish_after_strobe", 64'(cyc), 64'(last_strobe_cyc + 1));
            check("busy_at_finish", 64'(busy), 64'(0));
        end
    end

    // ---------------- reference model ----------------
    // Row-major walk of the whole matrix or its upper triangle; each
    // off-diagonal element of the triangle is also written transposed.
    task automatic model_load(input bit s);
        int k = 0;
        for (int i = 0; i < N; i++) begin
            for (int j = (s ? i : 0); j < N; j++) begin
                exp_q.push_back({AW'(i), AW'(j), beat_data[k]});
                if (s && i != j) exp_q.push_back({AW'(j), AW'(i), beat_data[k]});
                k++;
            end
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic start_load(input bit s);
        start = 1'b1;
        symmetric = s;
        tick();
        start = 1'b0;
        symmetric = 1'b0;
        check("busy_after_start", 64'(busy), 64'(1));
        check("owns_port_after_start", 64'(owns_port), 64'(1));
    endtask

    task automatic stream(input int gap_pct, input int start_at, output int stalls);
        stalls = 0;
        for (int k = 0; k < beat_data.size(); k++) begin
            int  guard = 0;
            bit  took = 0;
            while (!took) begin
                in_data  = beat_data[k];
                in_valid = ($urandom_range(0, 99) >= gap_pct);
                if (k == start_at && guard == 0) begin
                    start = 1'b1;
                    symmetric = 1'b1;
                end
                if (in_valid && !in_ready) stalls++;
                took = in_valid && in_ready;
                tick();
                start = 1'b0;
                symmetric = 1'b0;
                guard++;
                if (!took && guard > 100) begin
                    checks++;
                    errors++;
                    $display("FAIL beat_timeout: beat %0d not accepted within 100 cycles", k);
                    in_valid = 1'b0;
                    return;
                end
            end
        end
        in_valid = 1'b0;
    endtask

    task automatic fill_data(input int nb, input int base);
        beat_data.delete();
        for (int k = 0; k < nb; k++)
            beat_data.push_back(base != 0 ? SB'(base + k) : SB'($urandom));
    endtask

    task automatic run_load(input bit s, input int gap, input int base, input int start_at,
                            input int exp_strobes, input int exp_stalls);
        int stalls;
        int fin0;
        fill_data(s ? N * (N + 1) / 2 : N * N, base);
        exp_q.delete();
        model_load(s);
        strobe_cycles.delete();
        fin0 = fin_cnt;
        fin_expected = 1;
        start_load(s);
        stream(gap, start_at, stalls);
        for (int t = 0; t < 20 && fin_cnt == fin0; t++) tick();
        check("finished_count", 64'(fin_cnt - fin0), 64'(1));
        check("strobe_count", 64'(strobe_cycles.size()), 64'(exp_strobes));
        check("expected_queue_empty", 64'(exp_q.size()), 64'(0));
        if (gap == 0 && strobe_cycles.size() == exp_strobes)
            check("strobes_consecutive",
                  64'(strobe_cycles[exp_strobes-1] - strobe_cycles[0]), 64'(exp_strobes - 1));
        if (exp_stalls >= 0) check("ready_low_cycles", 64'(stalls), 64'(exp_stalls));
        tick();
        check("busy_after_finish", 64'(busy), 64'(0));
        exp_q.delete();
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_in_ready"}, 64'(in_ready), 64'(0));
        check({tag, "_write_ready"}, 64'(write_ready), 64'(0));
        check({tag, "_busy"}, 64'(busy), 64'(0));
        check({tag, "_owns_port"}, 64'(owns_port), 64'(0));
        check({tag, "_finished"}, 64'(finished), 64'(0));
        check({tag, "_row"}, 64'(write_row_addr), 64'(0));
        check({tag, "_col"}, 64'(write_col_addr), 64'(0));
        check({tag, "_data"}, 64'(write_data), 64'(0));
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        bit sym;
        int gap;
        int base;         // 0 = random data
        int start_at;     // beat index at which a stray start is pulsed, -1 = none
        int exp_strobes;
        int exp_stalls;   // -1 = not checked
    } vec_t;

    vec_t vecs[6];

    initial begin
        int fin0;
        int stalls;
        vecs[0] = '{sym: 1'b0, gap: 0,  base: 1,   start_at: -1, exp_strobes: 9, exp_stalls: 0};
        vecs[1] = '{sym: 1'b1, gap: 0,  base: 10,  start_at: -1, exp_strobes: 9, exp_stalls: 3};
        vecs[2] = '{sym: 1'b0, gap: 50, base: 1,   start_at: -1, exp_strobes: 9, exp_stalls: -1};
        vecs[3] = '{sym: 1'b1, gap: 40, base: 0,   start_at: -1, exp_strobes: 9, exp_stalls: -1};
        vecs[4] = '{sym: 1'b0, gap: 0,  base: 100, start_at: 3,  exp_strobes: 9, exp_stalls: 0};
        vecs[5] = '{sym: 1'b0, gap: 30, base: 0,   start_at: -1, exp_strobes: 9, exp_stalls: -1};

        rst = 1'b1; start = 1'b0; symmetric = 1'b0; abort = 1'b0;
        in_data = '0; in_valid = 1'b0;
        repeat (3) tick();
        check_all_zero("reset");
        rst = 1'b0;
        tick();

        for (int v = 0; v < 6; v++)
            run_load(vecs[v].sym, vecs[v].gap, vecs[v].base, vecs[v].start_at,
                     vecs[v].exp_strobes, vecs[v].exp_stalls);

        // Abort after 4 beats, with a valid beat offered in the abort cycle.
        fill_data(N * N, 0);
        exp_q.delete();
        model_load(1'b0);
        while (exp_q.size() > 4) void'(exp_q.pop_back());
        while (beat_data.size() > 4) void'(beat_data.pop_back());
        strobe_cycles.delete();
        fin0 = fin_cnt;
        fin_expected = 0;
        start_load(1'b0);
        stream(0, -1, stalls);
        abort = 1'b1;
        in_valid = 1'b1;
        in_data = 32'hdead_beef;
        tick();
        abort = 1'b0;
        in_valid = 1'b0;
        check("abort_busy", 64'(busy), 64'(0));
        check("abort_owns_port", 64'(owns_port), 64'(0));
        check("abort_in_ready", 64'(in_ready), 64'(0));
        repeat (6) tick();
        check("abort_strobe_count", 64'(strobe_cycles.size()), 64'(4));
        check("abort_queue_empty", 64'(exp_q.size()), 64'(0));
        check("abort_no_finish", 64'(fin_cnt - fin0), 64'(0));
        exp_q.delete();
        run_load(1'b0, 0, 0, -1, 9, 0);

        // Reset after 5 beats.
        fill_data(N * N, 0);
        exp_q.delete();
        model_load(1'b0);
        while (exp_q.size() > 5) void'(exp_q.pop_back());
        while (beat_data.size() > 5) void'(beat_data.pop_back());
        strobe_cycles.delete();
        fin0 = fin_cnt;
        fin_expected = 0;
        start_load(1'b0);
        stream(0, -1, stalls);
        rst = 1'b1;
        tick();
        check_all_zero("midreset");
        rst = 1'b0;
        repeat (4) tick();
        check("midreset_strobe_count", 64'(strobe_cycles.size()), 64'(5));
        check("midreset_queue_empty", 64'(exp_q.size()), 64'(0));
        check("midreset_no_finish", 64'(fin_cnt - fin0), 64'(0));
        exp_q.delete();
        run_load(1'b1, 0, 0, -1, 9, 3);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
